split_check_seq: RTL

Sequencer that evaluates a bank of split-constraint predicates one at a time and reports whether the candidate assignment satisfies all of them. It sits between the solver's candidate-assignment driver and the external mux over the split modules' 1-bit `x` outputs. For each job it drives a split index, waits a fixed settle time, samples the selected `x`, and returns a pass/fail summary over a valid/ready handshake.

---
 rtl/split_check_seq.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/split_check_seq.sv
// Purpose: walks split_sel across the split bank, samples each selected x after a settle window, reports a pass/fail summary.
// Latency: NUM_SPLITS*(EVAL_LAT+1) cycles from accept to done_valid; (fail_idx+1)*(EVAL_LAT+1) on a failure when SPLIT_EARLY_EXIT_EN is defined.
// Backpressure: one job at a time; start_ready is high only in IDLE, and the result is held in DONE until done_ready.
//
// Build option: define SPLIT_EARLY_EXIT_EN to stop the scan at the first split whose x is 0.
// Without it every split in the bank is evaluated and the latency is fixed.
module split_check_seq #(
    parameter int NUM_SPLITS = 64,
    parameter int IDX_W      = 6,
    parameter int EVAL_LAT   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start_valid,
    output logic             start_ready,
    output logic [IDX_W-1:0] split_sel,
    input  logic             split_x,
    output logic             busy,
    output logic             done_valid,
    input  logic             done_ready,
    output logic             all_sat,
    output logic [IDX_W-1:0] fail_idx,
    output logic [IDX_W:0]   sat_count
);

    // Settle counter runs 0 .. EVAL_LAT-1; it keeps at least one bit so the
    // declaration stays legal when EVAL_LAT is 0 or 1.
    localparam int CNT_W = (EVAL_LAT > 1) ? $clog2(EVAL_LAT) : 1;
    localparam bit HAS_SETTLE = (EVAL_LAT > 0);
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'((EVAL_LAT > 0) ? (EVAL_LAT - 1) : 0);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_SPLITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_SAMPLE = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    // Everything reported to the consumer travels together so it is held as one unit.
    typedef struct packed {
        logic             all_sat;
        logic [IDX_W-1:0] fail_idx;
        logic [IDX_W:0]   sat_count;
    } result_t;

    localparam result_t RESULT_INIT = '{all_sat: 1'b1, fail_idx: '0, sat_count: '0};

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] settle_cnt;
    result_t          result;

    logic             job_accept;
    logic             settle_end;
    logic             last_split;
    logic             stop_scan;
    logic             early_stop;

    // Window-entry state: with no settle time every split is sampled directly.
    state_t           st_window;
    assign st_window = HAS_SETTLE ? ST_SETTLE : ST_SAMPLE;

    assign job_accept = (state == ST_IDLE) && start_valid;
    assign settle_end = (settle_cnt == SETTLE_LAST);
    assign last_split = (split_sel == LAST_IDX);

`ifdef SPLIT_EARLY_EXIT_EN
    // A zero x ends the job immediately; fail_idx is that split and sat_count
    // is the number of passing splits ahead of it.
    assign early_stop = ~split_x;
`else
    // The whole bank is always scanned.
    assign early_stop = 1'b0;
`endif

    assign stop_scan = last_split || early_stop;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state selection: settle window, single-cycle sample, then advance or finish.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start_valid) begin
                    state_nxt = st_window;
                end
            end
            ST_SETTLE: begin
                if (settle_end) begin
                    state_nxt = ST_SAMPLE;
                end
            end
            ST_SAMPLE: begin
                if (stop_scan) begin
                    state_nxt = ST_DONE;
                end else begin
                    state_nxt = st_window;
                end
            end
            ST_DONE: begin
                if (done_ready) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    // Handshake outputs decoded from state; start_ready is masked while rst is
    // high so no request can be taken during the reset cycles.
    always_comb begin
        start_ready = (state == ST_IDLE) && !rst;
        busy        = (state != ST_IDLE);
        done_valid  = (state == ST_DONE);
    end

    // Settle counter: restarts on every new split and wraps at the end of the window.
    always_ff @(posedge clk) begin
        if (rst) begin
            settle_cnt <= '0;
        end else if (job_accept) begin
            settle_cnt <= '0;
        end else if (state == ST_SETTLE) begin
            if (settle_end) begin
                settle_cnt <= '0;
            end else begin
                settle_cnt <= settle_cnt + 1'b1;
            end
        end
    end

    // Split index: cleared on accept, stepped after each sample that is not
    // the final one, otherwise held (including across DONE and IDLE).
    always_ff @(posedge clk) begin
        if (rst) begin
            split_sel <= '0;
        end else if (job_accept) begin
            split_sel <= '0;
        end else if ((state == ST_SAMPLE) && !stop_scan) begin
            split_sel <= split_sel + 1'b1;
        end
    end

    // Result accumulation: count passing splits, latch only the first failing index.
    always_ff @(posedge clk) begin
        if (rst) begin
            result <= RESULT_INIT;
        end else if (job_accept) begin
            result <= RESULT_INIT;
        end else if (state == ST_SAMPLE) begin
            if (split_x) begin
                result.sat_count <= result.sat_count + 1'b1;
            end else if (result.all_sat) begin
                result.all_sat  <= 1'b0;
                result.fail_idx <= split_sel;
            end
        end
    end

    // Result ports follow the held result register.
    always_comb begin
        all_sat   = result.all_sat;
        fail_idx  = result.fail_idx;
        sat_count = result.sat_count;
    end

endmodule
